// File: rtl/sbox_pkg.sv
// Shared AES S-box definitions: byte type, affine constants and the inverse affine transform.
// The transform is also meant for reuse by the inverse-S-box top.
package sbox_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t SBOX_FWD_CONST = 8'h63;
  localparam byte_t SBOX_INV_CONST = 8'h05;

  // b[i] = s[(i+2)%8] ^ s[(i+5)%8] ^ s[(i+7)%8] ^ c[i], unrolled to keep every index constant
  function automatic byte_t inv_affine(byte_t s, byte_t c);
    byte_t b;
    b[0] = s[2] ^ s[5] ^ s[7] ^ c[0];
    b[1] = s[3] ^ s[6] ^ s[0] ^ c[1];
    b[2] = s[4] ^ s[7] ^ s[1] ^ c[2];
    b[3] = s[5] ^ s[0] ^ s[2] ^ c[3];
    b[4] = s[6] ^ s[1] ^ s[3] ^ c[4];
    b[5] = s[7] ^ s[2] ^ s[4] ^ c[5];
    b[6] = s[0] ^ s[3] ^ s[5] ^ c[6];
    b[7] = s[1] ^ s[4] ^ s[6] ^ c[7];
    return b;
  endfunction

endpackage

// File: rtl/s_box_inverse_affine_if.sv
// Byte stream with valid/ready handshake; master drives data/valid, slave drives ready.
interface s_box_inverse_affine_if;
  import sbox_pkg::*;

  byte_t data;
  logic  valid;
  logic  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/sbox_pipe_stage.sv
// One elastic register stage: holds {valid, data} and passes ready upstream.
module sbox_pipe_stage
  import sbox_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  byte_t in_data,
  input  logic  next_ready,
  output logic  valid,
  output byte_t data,
  output logic  ready
);

  logic  valid_r;
  byte_t data_r;

  assign ready = ~valid_r | next_ready;
  assign valid = valid_r;
  assign data  = data_r;

  // Stage register: advance when ready; an empty predecessor clears valid but keeps stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= 8'h00;
    end else if (ready) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end else begin
        data_r <= data_r;
      end
    end else begin
      valid_r <= valid_r;
      data_r  <= data_r;
    end
  end

endmodule

// File: rtl/s_box_inverse_affine.sv
// Streaming AES inverse affine stage: transform on input, LATENCY elastic stages, accepted-byte counter.
module s_box_inverse_affine
  import sbox_pkg::*;
#(
  parameter byte_t AFFINE_CONSTANT = SBOX_INV_CONST,
  parameter int    LATENCY         = 3,
  parameter int    CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  s_box_inverse_affine_if.slave  in_if,
  s_box_inverse_affine_if.master out_if,
  output logic [CNT_W-1:0]      count
);

  if ((LATENCY < 1) || (LATENCY > 8)) begin : g_latency_check
    $error("s_box_inverse_affine: LATENCY must be within 1..8");
  end

  // Index 0 is the transformed input; index k+1 is the output of stage k.
  logic  valid_s [0:LATENCY];
  byte_t data_s  [0:LATENCY];
  logic  ready_s [0:LATENCY];
  logic  in_xfer_s;
  logic [CNT_W-1:0] count_r;

  assign valid_s[0]       = in_if.valid;
  assign data_s[0]        = inv_affine(in_if.data, AFFINE_CONSTANT);
  assign ready_s[LATENCY] = out_if.ready;

  assign in_if.ready  = ready_s[0];
  assign out_if.valid = valid_s[LATENCY];
  assign out_if.data  = data_s[LATENCY];
  assign in_xfer_s    = in_if.valid & ready_s[0];
  assign count        = count_r;

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    sbox_pipe_stage u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (valid_s[k]),
      .in_data    (data_s[k]),
      .next_ready (ready_s[k+1]),
      .valid      (valid_s[k+1]),
      .data       (data_s[k+1]),
      .ready      (ready_s[k])
    );
  end

  // Accepted-byte counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (in_xfer_s) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: tb/tb_s_box_inverse_affine.sv
// Directed and random stream bench for s_box_inverse_affine with a queue-based scoreboard.
module tb_s_box_inverse_affine;

  localparam int LATENCY = 3;
  localparam int CNT_W   = 16;

  typedef struct {
    logic [7:0] exp;
    logic [7:0] orig;
    int         cyc;
  } item_t;

  logic clk;
  logic rst_n;
  logic [CNT_W-1:0] count;

  s_box_inverse_affine_if in_if ();
  s_box_inverse_affine_if out_if ();

  s_box_inverse_affine #(
    .AFFINE_CONSTANT (8'h05),
    .LATENCY         (LATENCY),
    .CNT_W           (CNT_W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in_if  (in_if),
    .out_if (out_if),
    .count  (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  item_t      q[$];
  int         total = 0;
  int         bad = 0;
  int         ncyc = 0;
  int         nout = 0;
  logic [CNT_W-1:0] cnt_model = '0;
  bit         lat_chk = 1'b0;
  bit         hold_pend = 1'b0;
  logic [7:0] hold_d = 8'h00;

  function automatic logic [7:0] rotl(logic [7:0] x, int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  // Inverse affine as rotations: rotl by 6/3/1 picks bits i+2, i+5, i+7.
  function automatic logic [7:0] m_inv(logic [7:0] s);
    return rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05;
  endfunction

  function automatic logic [7:0] m_fwd(logic [7:0] s);
    return s ^ rotl(s, 1) ^ rotl(s, 2) ^ rotl(s, 3) ^ rotl(s, 4) ^ 8'h63;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, sample 1 ns later, predict the transfers of the coming posedge.
  task automatic cyc(input logic iv, input logic [7:0] id, input logic ordy);
    item_t it;
    @(negedge clk);
    in_if.valid  = iv;
    in_if.data   = id;
    out_if.ready = ordy;
    #1;
    ncyc++;
    chk("count", 32'(count), 32'(cnt_model));
    if (hold_pend) begin
      chk("hold_valid", 32'(out_if.valid), 32'd1);
      chk("hold_data", 32'(out_if.data), 32'(hold_d));
    end
    if (out_if.valid && out_if.ready) begin
      total++;
      assert (q.size() != 0) else begin
        bad++;
        $error("FAIL spurious_out observed=%0h expected=none", out_if.data);
      end
      if (q.size() != 0) begin
        it = q.pop_front();
        chk("odata", 32'(out_if.data), 32'(it.exp));
        chk("fwd_roundtrip", 32'(m_fwd(out_if.data)), 32'(it.orig));
        if (lat_chk) chk("latency", 32'(ncyc - it.cyc), 32'(LATENCY));
        nout++;
      end
    end
    hold_pend = out_if.valid && !out_if.ready;
    hold_d    = out_if.data;
    if (in_if.valid && in_if.ready) begin
      it.exp  = m_inv(id);
      it.orig = id;
      it.cyc  = ncyc;
      q.push_back(it);
      cnt_model = cnt_model + 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] dir_in[4];
    logic [7:0] dir_out[4];
    int acc;
    int start_cnt;
    dir_in  = '{8'h63, 8'h7C, 8'h00, 8'h27};
    dir_out = '{8'h00, 8'h01, 8'h05, 8'hBB};

    rst_n = 1'b0;
    in_if.valid = 1'b0;
    in_if.data = 8'h00;
    out_if.ready = 1'b1;
    #12;
    chk("rst_ovalid", 32'(out_if.valid), 32'd0);
    chk("rst_odata", 32'(out_if.data), 32'h00);
    chk("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_iready", 32'(in_if.ready), 32'd1);

    // 1) single byte, exact latency, one output beat
    lat_chk = 1'b1;
    cyc(1'b1, 8'h27, 1'b1);
    for (int i = 0; i < LATENCY + 3; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("single_nout", 32'(nout), 32'd1);
    chk("single_count", 32'(count), 32'd1);

    // 2) back-to-back directed stream with known results
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, dir_in[i], 1'b1);
      chk("dir_model", 32'(q[q.size()-1].exp), 32'(dir_out[i]));
    end
    drain(LATENCY + 4);
    chk("dir_nout", 32'(nout), 32'd5);
    lat_chk = 1'b0;

    // 3) stall: only LATENCY bytes fit, then iready low and outputs frozen
    acc = 0;
    for (int i = 0; i < LATENCY + 4; i++) begin
      start_cnt = int'(cnt_model);
      cyc(1'b1, 8'(8'h10 + i), 1'b0);
      if (int'(cnt_model) != start_cnt) acc++;
    end
    chk("stall_accepts", 32'(acc), 32'(LATENCY));
    chk("stall_iready", 32'(in_if.ready), 32'd0);
    chk("stall_ovalid", 32'(out_if.valid), 32'd1);
    cyc(1'b1, 8'hA5, 1'b1);
    drain(LATENCY + 6);

    // 4a) all 256 values under random handshake
    cur = 8'h00;
    for (int n = 0; n < 4000; n++) begin
      start_cnt = int'(cnt_model);
      cyc(1'($urandom_range(0, 1)), cur, 1'($urandom_range(0, 1)));
      if (int'(cnt_model) != start_cnt) begin
        if (cur == 8'hFF) break;
        cur = cur + 8'h01;
      end
    end
    chk("sweep_done", 32'(cur), 32'hFF);
    drain(40);

    // 4b) 10k random bytes under random handshake
    acc = 0;
    for (int n = 0; n < 60000 && acc < 10000; n++) begin
      start_cnt = int'(cnt_model);
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      if (int'(cnt_model) != start_cnt) acc++;
    end
    chk("random_accepts", 32'(acc), 32'd10000);
    drain(40);

    // 5) asynchronous reset mid-stream
    for (int i = 0; i < LATENCY; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0);
    @(negedge clk);
    in_if.valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_ovalid", 32'(out_if.valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_odata", 32'(out_if.data), 32'h00);
    q.delete();
    cnt_model = '0;
    hold_pend = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < LATENCY + 3; i++) cyc(1'b0, 8'h00, 1'b1);
    lat_chk = 1'b1;
    cyc(1'b1, 8'h7C, 1'b1);
    drain(LATENCY + 4);
    chk("post_arst_count", 32'(count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
